// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM states, widths and
// the mux select code each requester needs.
package mux_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Indexed by requester, each entry is {switch2,switch1}.
  localparam logic [N_REQ-1:0][1:0] SEL_CODES = {2'b00, 2'b10, 2'b01, 2'b11};

endpackage

// File: rtl/mux.sv
// 32-bit 4:1 datapath mux steered by the two select lines.
module mux
  import mux_arb_pkg::*;
(
  input  logic [DATA_W-1:0] cin1,
  input  logic [DATA_W-1:0] cin2,
  input  logic [DATA_W-1:0] cin3,
  input  logic [DATA_W-1:0] cin4,
  input  logic              switch1,
  input  logic              switch2,
  output logic [DATA_W-1:0] cout
);

  always_comb begin
    case ({switch2, switch1})
      2'b11:   cout = cin1;
      2'b01:   cout = cin2;
      2'b10:   cout = cin3;
      default: cout = cin4;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for the shared mux, with bounded bursts and a
// registered valid/ready output stage.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [N_REQ-1:0]  gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              switch1,
  output logic              switch2,
  output logic              busy
);

  arb_state_t        state, state_next;
  logic [1:0]        ptr;
  logic [1:0]        owner;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] mux_out;
  logic              space;
  logic              beat;
  logic              last_beat;
  logic              exit_grant;

  // Lowest-offset requester from start wins; scanning downward lets it overwrite.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign {switch2, switch1} = SEL_CODES[owner];

  mux u_mux (
    .cin1    (din0),
    .cin2    (din1),
    .cin3    (din2),
    .cin4    (din3),
    .switch1 (switch1),
    .switch2 (switch2),
    .cout    (mux_out)
  );

  assign space      = !out_valid || out_ready;
  assign beat       = (state == GRANT) && req[owner] && space;
  assign last_beat  = beat && (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign exit_grant = (state == GRANT) && (!req[owner] || last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = GRANT;
      GRANT:   if (exit_grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == GRANT);
    gnt  = '0;
    if (beat) gnt[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && |req) begin
        owner    <= rr_pick(req, ptr);
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (exit_grant) ptr <= owner + 2'd1;
    end
  end

  // A new beat takes priority over draining, so accept+drain keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (beat) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed checks of mux_rr_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_mux_rr_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din0, din1, din2, din3;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        switch1, switch2;
  logic        busy;

  logic [31:0] din_q [4];
  int          left [4];
  logic [3:0]  g_seen;
  bit          rand_data;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          pulse_cnt;

  bit          m_busy;
  int          m_owner, m_beats, m_ptr;
  bit          m_valid;
  logic [31:0] m_data;

  assign din0 = din_q[0];
  assign din1 = din_q[1];
  assign din2 = din_q[2];
  assign din3 = din_q[3];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .switch1   (switch1),
    .switch2   (switch2),
    .busy      (busy)
  );

  function automatic logic [1:0] exp_sel(input int o);
    case (o)
      0:       exp_sel = 2'b11;
      1:       exp_sel = 2'b01;
      2:       exp_sel = 2'b10;
      default: exp_sel = 2'b00;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  // Requesters hold req/data until granted, then count down their remaining words.
  task automatic applyStimulus(input bit rdy);
    for (int k = 0; k < 4; k++) begin
      if (g_seen[k]) begin
        left[k]--;
        if (rand_data) din_q[k] = $urandom;
      end
      req[k] = (left[k] > 0);
    end
    g_seen    = '0;
    out_ready = rdy;
  endtask

  task automatic stepCycle();
    logic [3:0] eg;
    bit         sp, mbeat;
    #1;
    sp    = !m_valid || out_ready;
    mbeat = m_busy && req[m_owner] && sp;
    eg    = mbeat ? 4'(1 << m_owner) : 4'b0;
    checkOutput("gnt", 32'(gnt), 32'(eg));
    checkOutput("select", 32'({switch2, switch1}), 32'(exp_sel(m_owner)));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_data", out_data, m_data);
    g_seen = gnt;
    @(posedge clk);
    if (mbeat) begin
      m_data  = din_q[m_owner];
      m_valid = 1'b1;
      m_beats++;
      if (m_beats == MAXB) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
      end
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_busy && !req[m_owner]) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
      end else if (!m_busy && req != 4'b0) begin
        for (int i = 0; i < 4; i++) begin
          if (req[(m_ptr + i) % 4]) begin
            m_owner = (m_ptr + i) % 4;
            break;
          end
        end
        m_beats = 0;
        m_busy  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // mode 0: always ready, 1: random ready, 2: five-cycle stall after the first beat
  task automatic runCycles(input int n, input int mode, input int watch);
    bit rdy;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 9) < 7);
        default: rdy = !(i >= 2 && i < 7);
      endcase
      applyStimulus(rdy);
      stepCycle();
      if (watch >= 0 && g_seen[watch]) pulse_cnt++;
    end
  endtask

  task automatic midBurstReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_select", 32'({switch2, switch1}), 32'(2'b11));
    checkOutput("rst_busy", 32'(busy), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b1;
    g_seen    = '0;
    rand_data = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din_q[k] = $urandom;
      left[k]  = 0;
    end
    modelReset();
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_select", 32'({switch2, switch1}), 32'(2'b11));
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    rand_data = 1'b0;
    din_q[1]  = 32'hA5A5_0001;
    left[1]   = 5;
    pulse_cnt = 0;
    runCycles(12, 0, 1);
    checkOutput("single_pulses", 32'(pulse_cnt), 32'd5);

    rand_data = 1'b1;
    for (int k = 0; k < 4; k++) left[k] = 8;
    pulse_cnt = 0;
    runCycles(44, 0, 0);
    checkOutput("rr_owner0_pulses", 32'(pulse_cnt), 32'd8);

    left[2]   = 4;
    pulse_cnt = 0;
    runCycles(20, 2, 2);
    checkOutput("backpressure_pulses", 32'(pulse_cnt), 32'd4);

    left[3] = 2;
    left[0] = 3;
    runCycles(15, 0, -1);

    for (int k = 0; k < 4; k++) left[k] = 8;
    runCycles(3, 0, -1);
    midBurstReset();
    runCycles(60, 1, -1);

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (left[k] == 0 && g_seen[k] == 1'b0 && $urandom_range(0, 3) == 0) begin
          left[k]  = $urandom_range(1, 6);
          din_q[k] = $urandom;
        end
      end
      runCycles(1, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares the 32-bit 4:1 `mux` datapath among four requesters. It chooses one owner, drives the mux select lines `switch1`/`switch2`, and captures the selected word into a registered valid/ready output stage. Each grant covers a burst of at most `MAX_BURST` beats, so no requester can hold the datapath indefinitely. It sits between the four data producers and a single downstream consumer.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum beats per grant, range 1..15.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: `req[k]` means requester k has a word on `dink`.
- `din0`..`din3` in 32 each: requester data, wired to mux inputs `cin1`..`cin4`.
- `gnt` out 4: one-hot beat-accept strobe. `gnt[k]`=1 means the word on `dink` is taken this cycle.
- `out_valid` out 1: output register holds a word.
- `out_data` out 32: registered word.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `switch1`, `switch2` out 1 each: mux select lines.
- `busy` out 1: high while in GRANT.

## Operation
- **Select encoding** as {switch2,switch1}:
  - owner 0 → 11 (`cin1`)
  - owner 1 → 01
  - owner 2 → 10
  - owner 3 → 00
  - Select comes combinationally from the `owner` register and holds its value in IDLE.
- **FSM states:** IDLE, GRANT.
- **IDLE:**
  - If any `req` is high, pick the first requester at or after `ptr`, wrapping modulo 4.
  - Load `owner`, clear `beat_cnt`, and go to GRANT.
  - With no request, stay in IDLE.
- **Space** means `!out_valid || out_ready`.
- **GRANT beat:**
  - When `req[owner] && space`, assert `gnt[owner]`.
  - Load `out_data` with the mux output, set `out_valid`, and increment `beat_cnt`.
- **Drain:** when `out_valid && out_ready` and no beat occurs in the same cycle, clear `out_valid`.
- **Stall:** while `req[owner]` is high with no space, stay in GRANT, `gnt`=0, and hold `out_data`.
- **Exit from GRANT** to IDLE when either:
  - `req[owner]`=0 (no beat that cycle), or
  - the beat just accepted makes `beat_cnt`==`MAX_BURST`.
- **On exit:** `ptr` ← (`owner`+1) mod 4.
- **Other requests:** requests from non-owners are ignored during GRANT. Requesters must hold `req` and `dink` stable until their `gnt` arrives.
- **`gnt` pattern:** at most one bit high per cycle. It is never high in IDLE or during reset.

## Timing
- **Reset values** (asynchronous, applied immediately on `rst_n`=0):
  - state IDLE, `ptr`=0, `owner`=0, `beat_cnt`=0
  - `gnt`=0, `out_valid`=0, `out_data`=0, `busy`=0
  - {switch2,switch1}=11
- **Arbitration latency:** `req` seen in IDLE at edge N → GRANT at N+1. `gnt` can be high in the cycle after N+1's edge, and `out_valid` rises at the edge after that.
- **Throughput:**
  - One beat per cycle while `out_ready`=1.
  - One idle arbitration cycle between grants.
  - Full burst of `MAX_BURST` beats occupies `MAX_BURST`+1 cycles.
- **Simultaneous events:** accept and drain in the same cycle keep `out_valid`=1 with the new data.
- **Wrap-around:**
  - `ptr` wraps 3→0.
  - `beat_cnt` resets on every new grant and never exceeds `MAX_BURST`.
- **Reset mid-burst:** the in-flight output word is dropped and arbitration restarts from requester 0.

## Structure
- Shared package `mux_arb_pkg` holds:
  - FSM state encodings
  - the four select codes indexed by requester
  - `N_REQ`=4
  - `DATA_W`=32
  - `beat_cnt` width (4)
- Sub-module: one instance of the existing `mux` as the datapath, driven by `switch1`/`switch2`. The round-robin priority pick is an internal function, not a separate module.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-burst with `out_valid`=1.
  - Required: `out_valid`=0, `gnt`=0, {switch2,switch1}=11 without waiting for a clock edge, then first grant after release goes to the lowest requester at or after index 0.
- **Single requester:**
  - Stimulus: `req`=0010, `din1`=32'hA5A5_0001, `out_ready`=1.
  - Required: select=01, `gnt`=0010 for 4 consecutive cycles, `out_data`=32'hA5A5_0001 for 4 beats, then one idle cycle before regrant.
- **Round-robin:**
  - Stimulus: `req`=1111 held.
  - Required: owners 0,1,2,3,0 in order, each granted exactly `MAX_BURST`=4 beats, select sequence 11,01,10,00,11.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 5 cycles during owner 2's burst.
  - Required: one beat accepted, then `gnt`=0 and `out_data` stable for the stall, and the burst completes with exactly 4 `gnt` pulses total.
- **Early release:**
  - Stimulus: owner 3 drops `req` after 2 beats while `req[0]` is high.
  - Required: return to IDLE, `ptr`=0, next owner 0, select=11.
- **Accept and drain:**
  - Stimulus: `out_valid`=1 and `out_ready`=1 with a new beat in the same cycle.
  - Required: `out_valid` stays 1 and `out_data` updates to the new word with no bubble.
